sync_fifo_param: RTL and testbench

- Parametrised single-clock synchronous FIFO; next generation of the team's 4x4 FIFO.
- Adds configurable data width and depth, occupancy count, and programmable almost-full/almost-empty thresholds.
- Adds defined full/empty boundary rules and overflow/underflow error pulses.
- Generic buffering element between producer/consumer blocks in one clock domain.

---
 rtl/fifo_pkg.sv | 11 +
 rtl/fifo_ram.sv | 21 ++
 rtl/sync_fifo_param.sv | 93 +++++++++
 tb/tb_sync_fifo_param.sv | 125 ++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, address-width helper and pointer type for sync_fifo_param.
package fifo_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    function automatic int addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    typedef logic [addr_w(DEF_DEPTH):0] def_ptr_t;
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x DATA_W storage with one synchronous write port and one asynchronous read port.
module fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with count, thresholds and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is registered 1-cycle read.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int ADDR_W  = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en,
    input  logic              read_en,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);
    typedef logic [ADDR_W:0] ptr_t;

    ptr_t              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              rd_acc, wr_acc;
    logic [DATA_W-1:0] rd_data;

    // Wrap bit distinguishes full from empty when the indices coincide.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign empty        = wr_ptr_q == rd_ptr_q;
    assign full         = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                          (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign almost_full  = int'(count) >= AF_LEVEL;
    assign almost_empty = int'(count) <= AE_LEVEL;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    always_comb begin
        rd_acc   = read_en && !empty;
        wr_acc   = write_en && (!full || rd_acc);
        wr_ptr_d = wr_acc ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
        ovf_d    = write_en && !wr_acc;
        unf_d    = read_en && !rd_acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign data_out = empty ? '0 : rd_data;
`else
    logic [DATA_W-1:0] dout_q, dout_d;

    always_comb dout_d = rd_acc ? rd_data : dout_q;

    always_ff @(posedge clk) begin
        if (rst) dout_q <= '0;
        else     dout_q <= dout_d;
    end

    assign data_out = dout_q;
`endif

    fifo_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (wr_acc),
        .waddr(wr_ptr_q[ADDR_W-1:0]),
        .wdata(data_in),
        .raddr(rd_ptr_q[ADDR_W-1:0]),
        .rdata(rd_data)
    );
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed plus random stimulus against a queue-based reference model.
module tb_sync_fifo_param;
    localparam int DW = 8;
    localparam int DP = 4;
    localparam int AF = 3;
    localparam int AE = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          write_en = 1'b0;
    logic          read_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [2:0]    count;

    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = '0;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .DATA_W  (DW),
        .DEPTH   (DP),
        .AF_LEVEL(AF),
        .AE_LEVEL(AE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .write_en    (write_en),
        .read_en     (read_en),
        .data_in     (data_in),
        .data_out    (data_out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, then compare all outputs.
    task automatic step(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
        logic ra, wa;
        int   n;
        rst = r; write_en = w; read_en = rd; data_in = d;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            ra = rd && q.size() > 0;
            wa = w && (q.size() < DP || ra);
            m_ovf = w && !wa;
            m_unf = rd && !ra;
            if (ra) m_dout = q.pop_front();
            if (wa) q.push_back(d);
        end
        #1;
        n = q.size();
        check("count", 32'(count), 32'(n));
        check("empty", 32'(empty), 32'(n == 0));
        check("full", 32'(full), 32'(n == DP));
        check("almost_full", 32'(almost_full), 32'(n >= AF));
        check("almost_empty", 32'(almost_empty), 32'(n <= AE));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
        check("data_out", 32'(data_out), (n > 0) ? 32'(q[0]) : 32'h0);
`else
        check("data_out", 32'(data_out), 32'(m_dout));
`endif
    endtask

    initial begin
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        for (int i = 1; i <= 4; i++) step(0, 1, 0, 8'hA0 + 8'(i));
        step(0, 1, 0, 8'hEE);
        step(0, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00);
        step(0, 0, 1, 8'h00);
        step(0, 0, 0, 8'h00);
        for (int i = 1; i <= 4; i++) step(0, 1, 0, 8'hB0 + 8'(i));
        step(0, 1, 1, 8'h55);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00);
        step(0, 1, 1, 8'h66);
        step(0, 0, 1, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 8'(i));
            step(0, 0, 1, 8'h00);
        end
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'hC0 + 8'(i));
        step(1, 1, 0, 8'h99);
        step(0, 1, 0, 8'h77);
        step(0, 0, 0, 8'h00);
        step(0, 0, 1, 8'h00);
        step(0, 0, 0, 8'h00);
        for (int i = 0; i < 600; i++) begin
            logic wr_bias;
            wr_bias = (i / 100) % 2 == 0;
            step($urandom_range(0, 59) == 0,
                 wr_bias ? $urandom_range(0, 3) != 0 : $urandom_range(0, 3) == 0,
                 wr_bias ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0,
                 8'($urandom));
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
